mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter_pkg.sv | 28 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 29 ++
 rtl/mux4_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: state
// encodings, the default hold length and the post-reset priority pointer.
package mux4_rr_arbiter_pkg;

    // Arbiter states: no owner, or one requester currently granted.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Default maximum consecutive grant cycles per ownership.
    localparam int unsigned HOLD_DEFAULT = 4;

    // Width of the ownership counter; HOLD must fit in it (1..255).
    localparam int unsigned CNT_W = 8;

    // Last-served pointer after reset: 3, so requester 0 is scanned first.
    localparam logic [1:0] LAST_RESET = 2'd3;

    // Convert a 2-bit requester index into a 4-bit one-hot grant vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] vec;
        vec = 4'b0000;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters. It scans the
// indices after the last-served one, wrapping around, and returns the
// first requester found. The last-served index is scanned last, so it
// only wins when it is the sole requester. Usable by any 4-way scheduler.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] win_o,
    output logic       any_o
);

    logic [1:0] idx;

    // Walk the priority ring from furthest to nearest so the nearest hit wins.
    always_comb begin
        idx   = 2'd0;
        win_o = last_i;
        any_o = |req_i;
        for (int k = 4; k >= 1; k--) begin
            idx = last_i + 2'(k);
            if (req_i[idx]) begin
                win_o = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux between four
// requesters. Grants are one-hot and registered; the select pair
// {s0_o, s1_o} carries the owner's index so the owner's data reaches the
// mux output. Each ownership lasts at most HOLD cycles, after which the
// next requester in ring order takes over with no idle cycle in between.
// The selects keep the last owner's index while idle, so the mux output
// does not move until a new grant is issued.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int unsigned HOLD = HOLD_DEFAULT
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    output logic [3:0] gnt_o,
    output logic       s0_o,
    output logic       s1_o,
    output logic       busy_o
);

    localparam logic [CNT_W-1:0] HOLD_W = CNT_W'(HOLD);

    state_t           state_q, state_d;
    logic [1:0]       last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic             s0_q,    s0_d;
    logic             s1_q,    s1_d;
    logic             busy_q,  busy_d;

    logic [1:0]       win;
    logic             anyReq;
    logic             releaseNow;

    rr_pick4 u_pick (
        .req_i  (req_i),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (anyReq)
    );

    // The owner gives up the grant when it stops requesting or has used its full hold.
    always_comb begin
        releaseNow = (!req_i[last_q]) || (cnt_q == HOLD_W);
    end

    // Next-state logic: pick a new owner when idle or on release, otherwise count up.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        busy_d  = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    state_d = ST_GRANT;
                    last_d  = win;
                    cnt_d   = CNT_W'(1);
                    gnt_d   = onehot4(win);
                    s0_d    = win[1];
                    s1_d    = win[0];
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (releaseNow) begin
                    if (anyReq) begin
                        state_d = ST_GRANT;
                        last_d  = win;
                        cnt_d   = CNT_W'(1);
                        gnt_d   = onehot4(win);
                        s0_d    = win[1];
                        s1_d    = win[0];
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any grant and restores priority to requester 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= LAST_RESET;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign s0_o   = s0_q;
    assign s1_o   = s1_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter with HOLD=4. Each step drives
// request/reset just after a rising edge, lets one edge pass, then
// compares grant, selects and busy against hand-computed values.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       busy;

    int checkCount;
    int failCount;

    mux4_rr_arbiter #(.HOLD(4)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .req_i  (req),
        .gnt_o  (gnt),
        .s0_o   (s0),
        .s1_o   (s1),
        .busy_o (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs, let one rising edge pass, and settle 1 unit past it.
    task automatic applyStimulus(input logic [3:0] r, input logic rs);
        rst = rs;
        req = r;
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got {busy,s0,s1,gnt}=%b expected %b", tag, observed[6:0], expected[6:0]);
        end
    endtask

    // Compare all outputs at once against an expected grant, select pair and busy.
    task automatic checkState(input string tag, input logic [3:0] expGnt, input logic [1:0] expSel, input logic expBusy);
        checkOutput(tag, {1'b0, busy, s0, s1, gnt}, {1'b0, expBusy, expSel, expGnt});
    endtask

    initial begin
        logic [1:0] owner;
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        req = 4'b0000;

        // Reset for two cycles, then a single requester 0 held continuously.
        applyStimulus(4'b0000, 1'b1);
        checkState("reset1", 4'b0000, 2'b00, 1'b0);
        applyStimulus(4'b0000, 1'b1);
        checkState("reset2", 4'b0000, 2'b00, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(4'b0001, 1'b0);
            checkState($sformatf("single%0d", i), 4'b0001, 2'b00, 1'b1);
        end

        // All four requesting: each owner for exactly 4 cycles, order 0,1,2,3,0.
        applyStimulus(4'b0000, 1'b1);
        checkState("reset3", 4'b0000, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b1111, 1'b0);
            owner = 2'((i / 4) % 4);
            checkState($sformatf("rr%0d", i), 4'b0001 << owner, owner, 1'b1);
        end

        // Early release: owner 2 drops after 2 cycles while requester 0 waits.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b0100, 1'b0);
        checkState("early_grant2", 4'b0100, 2'b10, 1'b1);
        applyStimulus(4'b0101, 1'b0);
        checkState("early_hold2", 4'b0100, 2'b10, 1'b1);
        applyStimulus(4'b0001, 1'b0);
        checkState("early_to0", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0011, 1'b0);
        checkState("early_cnt2", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0011, 1'b0);
        checkState("early_cnt3", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0011, 1'b0);
        checkState("early_cnt4", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0011, 1'b0);
        checkState("early_to1", 4'b0010, 2'b01, 1'b1);

        // Drop to idle: sole owner 3 releases, selects hold 11, then 0101 goes to 0.
        applyStimulus(4'b0000, 1'b1);
        applyStimulus(4'b1000, 1'b0);
        checkState("idle_grant3", 4'b1000, 2'b11, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        checkState("idle_drop", 4'b0000, 2'b11, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        checkState("idle_stay", 4'b0000, 2'b11, 1'b0);
        applyStimulus(4'b0101, 1'b0);
        checkState("idle_win0", 4'b0001, 2'b00, 1'b1);

        // Non-owner request arriving at count 2 waits until the hold expires.
        applyStimulus(4'b0001, 1'b0);
        checkState("nonown_c2", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0011, 1'b0);
        checkState("nonown_c3", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0011, 1'b0);
        checkState("nonown_c4", 4'b0001, 2'b00, 1'b1);
        applyStimulus(4'b0011, 1'b0);
        checkState("nonown_to1", 4'b0010, 2'b01, 1'b1);

        // Reset mid-grant drops the grant; priority returns to requester 0.
        applyStimulus(4'b1111, 1'b1);
        checkState("midrst", 4'b0000, 2'b00, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        checkState("postrst0", 4'b0001, 2'b00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
